// File: rtl/add8_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision add sequencer.
package add8_seq_pkg;

    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-byte operand still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add8.sv
// 8-bit ripple-carry adder; purely combinational.
module add8
    import add8_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] w_c;

    // NOTE: every signal written here gets a value before the loop, so no latch is inferred.
    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
        end
    end

    assign cout = w_c[BYTE_W];

endmodule

// File: rtl/add8_mp_seq.sv
// Multi-precision adder: feeds one add8 a byte per clock, LSB first, carry chained through a register.
module add8_mp_seq
    import add8_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a_in,
    input  logic [BYTE_W*NBYTES-1:0] b_in,
    input  logic                     cin_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum_out,
    output logic                     cout_out,
    output logic                     busy
);

    localparam int CNT_W = cnt_width(NBYTES);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [NBYTES-1:0][BYTE_W-1:0]   r_a;
    logic [NBYTES-1:0][BYTE_W-1:0]   r_b;
    logic [NBYTES-1:0][BYTE_W-1:0]   r_sum;
    logic                            r_carry;
    logic [CNT_W-1:0]                r_idx;

    logic                            w_accept;
    logic                            w_last;
    logic [BYTE_W-1:0]               w_sum_byte;
    logic                            w_cout;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == CNT_W'(NBYTES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The byte mux is the only logic in front of the shared adder.
    add8 u_add8 (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_sum_byte),
        .cout (w_cout)
    );

    // Operand and result storage is small and visible on the outputs, so all of it is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_sum   <= '0;
            r_carry <= cin_in;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx] <= w_sum_byte;
            r_carry      <= w_cout;
            if (!w_last) r_idx <= r_idx + CNT_W'(1);
        end
    end

    assign sum_out  = r_sum;
    assign cout_out = r_carry;

endmodule

// File: tb/tb_add8_mp_seq.sv
// Directed self-checking bench for add8_mp_seq with NBYTES = 4.
module tb_add8_mp_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc_cnt = 0;

    add8_mp_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, then present one operand set for exactly one accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int accept_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_timeout", W'(in_ready), W'(1));
        a_in = a; b_in = b; cin_in = c; in_valid = 1'b1;
        step();
        accept_cyc = cyc_cnt;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    int t0, t1, lat;
    logic [W-1:0] held_sum;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; cin_in = 1'b0;
        step(); step();
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_sum",       sum_out,       32'h0);
        check("rst_cout",      W'(cout_out),  W'(0));
        rst = 1'b0;
        step();

        // Single byte, no carry out of byte 0.
        issue(32'h0000_00FF, 32'h0000_0000, 1'b0, t0);
        check("t1_busy", W'(busy), W'(1));
        check("t1_in_ready_run", W'(in_ready), W'(0));
        wait_result(lat);
        check("t1_latency", W'(lat), W'(4));
        check("t1_sum",  sum_out,      32'h0000_00FF);
        check("t1_cout", W'(cout_out), W'(0));
        step();
        check("t1_done_one_cycle", W'(out_valid), W'(0));
        check("t1_in_ready_after", W'(in_ready),  W'(1));

        // Carry ripples through every byte and out.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, t0);
        wait_result(lat);
        check("t2_latency", W'(lat), W'(4));
        check("t2_sum",  sum_out,      32'h0000_0000);
        check("t2_cout", W'(cout_out), W'(1));
        step();

        // Carry-in used; no carries between bytes.
        issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, t0);
        wait_result(lat);
        check("t3_sum",  sum_out,      32'h2143_6588);
        check("t3_cout", W'(cout_out), W'(0));
        step();

        // Backpressure: result held for 5 cycles, new in_valid ignored.
        out_ready = 1'b0;
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, t0);
        wait_result(lat);
        check("bp_sum", sum_out, 32'h3333_3333);
        held_sum = sum_out;
        a_in = 32'hAAAA_AAAA; b_in = 32'h5555_5555; cin_in = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid_hold", W'(out_valid), W'(1));
            check("bp_sum_hold",   sum_out,       held_sum);
            check("bp_cout_hold",  W'(cout_out),  W'(0));
            check("bp_in_ready",   W'(in_ready),  W'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", W'(out_valid), W'(0));
        check("bp_release_ready", W'(in_ready),  W'(1));
        step();
        check("bp_not_queued_busy", W'(busy), W'(0));

        // Reset while the counter sits at byte 2.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, t0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_in_ready",  W'(in_ready),  W'(1));
        check("mr_out_valid", W'(out_valid), W'(0));
        check("mr_busy",      W'(busy),      W'(0));
        check("mr_sum",       sum_out,       32'h0);
        check("mr_cout",      W'(cout_out),  W'(0));
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            step();
        end
        check("mr_no_result", W'(lat), W'(0));
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, t0);
        wait_result(lat);
        check("mr_after_sum",  sum_out,      32'h0000_0002);
        check("mr_after_cout", W'(cout_out), W'(0));
        step();

        // Back-to-back with out_ready tied high.
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, t0);
        wait_result(lat);
        check("b2b_0_sum", sum_out, 32'h0000_0003);
        check("b2b_0_cout", W'(cout_out), W'(0));
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, t1);
        check("b2b_interval_1", W'(t1 - t0), W'(6));
        wait_result(lat);
        check("b2b_1_sum", sum_out, 32'h0000_0000);
        check("b2b_1_cout", W'(cout_out), W'(1));
        t0 = t1;
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b1, t1);
        check("b2b_interval_2", W'(t1 - t0), W'(6));
        wait_result(lat);
        check("b2b_2_sum", sum_out, 32'h0001_0001);
        check("b2b_2_cout", W'(cout_out), W'(0));
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add8_mp_seq.md
# add8_mp_seq

Multi-precision add sequencer that shares a single `add8` ripple-adder datapath across the bytes of a wide operand pair. It accepts two NBYTES-wide operands and a carry-in through a valid/ready handshake. It feeds the operands to `add8` one byte per clock, LSB first, and chains `cout` into the next byte's `cin` through a carry register. It then presents the full sum and the final carry-out through a second valid/ready handshake. It sits between an operand producer and any consumer that needs additions wider than 8 bits, without replicating adder hardware.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands `a_in`, `b_in` and `cin_in` are valid.
- in_ready  out  1  sequencer can accept operands.
- a_in  in  8*NBYTES  operand A.
- b_in  in  8*NBYTES  operand B.
- cin_in  in  1  carry-in to byte 0.
- out_valid  out  1  `sum_out` and `cout_out` are valid.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  8*NBYTES  A + B + cin, modulo 2^(8*NBYTES).
- cout_out  out  1  carry-out of the MSB byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready` = 1. On `in_valid` & `in_ready`:
    - latch `a_in` and `b_in` into operand registers;
    - load the carry register with `cin_in`;
    - clear the byte counter and sum register;
    - go to RUN.
  - RUN: `add8` inputs are driven as follows:
    - `a` = operand A byte[idx], `b` = operand B byte[idx];
    - `cin` = carry register.
  - RUN, each edge:
    - write sum byte[idx] ← `add8.sum`;
    - carry register ← `add8.cout`;
    - idx ← idx+1.
  - RUN exit: when idx = NBYTES-1, go to DONE instead of incrementing. The counter never wraps past NBYTES-1.
  - DONE:
    - `out_valid` = 1;
    - `sum_out` = sum register;
    - `cout_out` = carry register.
  - DONE exit: on `out_ready`, go to IDLE. `out_valid`, `sum_out` and `cout_out` hold stable until then.
- `in_ready` is low in RUN and DONE. `in_valid` in those states is ignored, not queued.
- `sum_out` and `cout_out` outside DONE: they show the register contents (partial sum). They are only meaningful when `out_valid` = 1.
- Width rules:
  - byte counter is max(1, $clog2(NBYTES)) bits;
  - sum register is 8*NBYTES bits;
  - carry register is 1 bit.
- NBYTES = 1: RUN lasts exactly one cycle.
- Reset, in any state including mid-RUN or DONE:
  - state → IDLE;
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1;
  - sum register, operand registers, carry register and counter = 0;
  - `sum_out` = 0, `cout_out` = 0.
  - The in-flight operation is discarded and no result is produced.
- `rst` has priority over every handshake in the same cycle.

## Timing
- Accept edge e0. Bytes 0..NBYTES-1 are written at edges e1..eN, where N = NBYTES.
- `out_valid` rises after eN: latency is NBYTES cycles from accept edge to `out_valid`.
- Result leaves at the first edge in DONE with `out_ready` = 1. `in_ready` is high in the following cycle.
- Minimum issue interval is NBYTES+2 cycles: 1 IDLE, NBYTES RUN, ≥1 DONE.
- `out_ready` held high before DONE: DONE lasts exactly one cycle.
- `add8` path: combinational between registers. The only critical path is the mux from operand byte to `add8` to carry/sum registers.

## Structure
- Package `add8_seq_pkg`:
  - state enum (IDLE, RUN, DONE);
  - BYTE_W = 8;
  - NBYTES default;
  - byte-counter width function.
- Sub-module: one `add8` instance (ports `a`, `b`, `cin`, `sum`, `cout`), used unchanged. The sequencer contains only registers, the FSM and the byte mux.

## Test plan
All scenarios use NBYTES = 4.
- **Single-byte all-ones:** A=0x000000FF, B=0x00000000, cin=0 → `sum_out` = 0x000000FF, `cout_out` = 0, `out_valid` exactly 4 cycles after accept.
- **Full carry ripple:** A=0xFFFFFFFF, B=0x00000001, cin=0 → `sum_out` = 0x00000000, `cout_out` = 1.
- **Carry-in use and byte isolation:** A=0x12345678, B=0x0F0F0F0F, cin=1 → `sum_out` = 0x21436588, `cout_out` = 0.
- **Backpressure:** `out_ready` held low 5 cycles in DONE → `out_valid` and `sum_out` stable throughout, `in_ready` = 0, a new `in_valid` is ignored. Release `out_ready` → `in_ready` = 1 next cycle.
- **Reset mid-RUN:** assert `rst` one cycle at byte index 2 → next cycle all outputs are at reset values, `out_valid` never rises, a following op with A=0x00000001, B=0x00000001 returns 0x00000002.
- **Back-to-back:** `out_ready` tied high, 3 ops issued as soon as `in_ready` rises → results in order, issue interval 6 cycles.
